mipi_csi_pkt_parser: RTL and testbench
======================================

// Module: mipi_csi_pkt_parser
// PURPOSE
//  CSI-2 packet-layer stage directly upstream of the RAW10 pixel unpacker.
//  - Takes byte-aligned, lane-merged 32-bit words from the D-PHY receive path.
//  - Parses packet headers and checks their ECC.
//  - Emits frame/line sync pulses from short packets.
//  - Strips header and CRC footer from long packets.
//  - Forwards only RAW10 payload of the selected virtual channel, as a contiguous valid burst.
// PARAMETERS
//  DT_FILTER   6'h2B  long-packet data type forwarded (RAW10)
//  VC_FILTER   2'd0   virtual channel forwarded
//  ERR_CNT_W   16     width of saturating error counter
// PORTS
//  clk_i         in   1   pixel-domain clock, all logic on posedge
//  reset_n       in   1   async active-low reset
//  word_i        in   32  merged lane bytes, byte0 = word_i[7:0] (first on wire)
//  word_valid_i  in   1   word_i valid this cycle
//  sot_i         in   1   with word_valid_i: this word is first after Start-of-Transmission
//  data_o        out  32  payload word to unpacker
//  data_valid_o  out  1   data_o valid; held high for every payload word of a forwarded packet
//  byte_en_o     out  4   valid payload bytes in data_o (4'hF; tail 4'h1/3/7)
//  fs_o fe_o     out  1   one-cycle pulses: Frame Start / Frame End short packet
//  ls_o le_o     out  1   one-cycle pulses: Line Start / Line End short packet
//  frame_num_o   out  16  WC field of last good FS packet
//  line_wc_o     out  16  WC of last forwarded long packet
//  ecc_err_o     out  1   one-cycle pulse on header ECC mismatch
//  err_count_o   out  ERR_CNT_W  saturating count of ECC errors plus aborted packets
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE. Every output registered; latency 1 cycle word_i -> data_o.
//  - Header word: DI = byte0 (VC=[7:6], DT=[5:0]), WC = {byte2, byte1}, ECC = byte3.
//  - ECC: standard CSI-2 6-bit Hamming over the 24 header bits; ECC[7:6] must be 0.
//    Detect only, no correction.
//  - States and transitions:
//    IDLE: ignore words until word_valid_i & sot_i; that word is the header.
//      ECC bad -> ecc_err_o, count++, stay IDLE.
//      DT < 6'h10 -> short packet: pulse fs/fe/ls/le for DT 0/1/2/3 only if VC==VC_FILTER;
//        FS also latches frame_num_o; stay IDLE.
//      DT >= 6'h10 -> long packet, load remaining = WC:
//        WC==0 -> FOOTER;
//        else PAYLOAD (fwd = VC==VC_FILTER && DT==DT_FILTER).
//    PAYLOAD: each valid word consumes min(4, remaining) bytes.
//      If fwd: data_valid_o=1, byte_en_o per consumed bytes.
//      On last payload word, r = WC%4:
//        r==0 or r==3 -> FOOTER (CRC byte(s) in next word);
//        r==1 or 2 -> CRC completes in this word -> IDLE.
//      If fwd: line_wc_o <= WC at packet end.
//    FOOTER: next valid word holds the remaining CRC byte(s); discard it -> IDLE. CRC not checked.
//  - data_valid_o drops to 0 in any cycle with word_valid_i=0 or outside a forwarded payload.
//    The unpacker treats a drop as a packet boundary, so word_valid_i gaps inside payload
//    are illegal upstream.
//  - sot_i in PAYLOAD/FOOTER: abort packet, count++, data_valid_o=0 that cycle.
//    The same word is processed as a new header (IDLE rules) in the same cycle.
//  - Remaining counter: 16-bit, decrement never underflows. err_count_o saturates at all-ones.
//  - Async reset mid-packet: immediate return to IDLE, outputs 0; next packet needs sot_i.
// TESTING
//  - FS: sot word {ECC_ok, 8'h00, 8'h01, 8'h00} -> fs_o pulse 1 cycle later, frame_num_o=16'h0001,
//    no data_valid_o.
//  - RAW10 line WC=10: header DI=0x2B, then 3 words -> data_valid_o high 3 consecutive cycles,
//    byte_en F,F,3; IDLE next (no FOOTER); line_wc_o=10.
//  - WC=8, DI=0x2B: 2 payload words with byte_en F,F, then footer word consumed with
//    data_valid_o=0; next sot header parsed correctly.
//  - ECC corrupt: valid LS header with byte3^8'h01 -> ecc_err_o pulse, ls_o stays 0,
//    err_count_o=1.
//  - Filtering: DI=0x6B (VC1) and DI=0x2A (RAW8) long packets WC=16 -> data_valid_o never asserted;
//    word count still tracked (following header parsed OK).
//  - Abort: sot_i after 2 of 5 payload words -> err_count_o+1, new header honoured same cycle;
//    async reset asserted mid-payload -> all outputs 0 immediately.

Source files
------------

// File: rtl/mipi_csi_pkt_parser.sv
// CSI-2 packet-layer parser: header ECC check, short-packet sync pulses and payload
// extraction of one VC/DT stream for the RAW10 unpacker. All outputs registered.
module mipi_csi_pkt_parser #(
  parameter logic [5:0]  DT_FILTER = 6'h2B,
  parameter logic [1:0]  VC_FILTER = 2'd0,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n,
  input  logic [31:0]          word_i,
  input  logic                 word_valid_i,
  input  logic                 sot_i,
  output logic [31:0]          data_o,
  output logic                 data_valid_o,
  output logic [3:0]           byte_en_o,
  output logic                 fs_o,
  output logic                 fe_o,
  output logic                 ls_o,
  output logic                 le_o,
  output logic [15:0]          frame_num_o,
  output logic [15:0]          line_wc_o,
  output logic                 ecc_err_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  typedef enum logic [1:0] {StIdle, StPayload, StFooter} state_e;

  state_e         state_q, state_d;
  logic [15:0]    remaining_q, remaining_d;
  logic [15:0]    wc_q, wc_d;
  logic           fwd_q, fwd_d;

  logic [31:0]    data_q, data_d;
  logic           data_valid_q, data_valid_d;
  logic [3:0]     byte_en_q, byte_en_d;
  logic           fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic [15:0]    frame_num_q, frame_num_d;
  logic [15:0]    line_wc_q, line_wc_d;
  logic           ecc_err_q, ecc_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Header fields
  logic [23:0] hdr;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic [7:0]  hdr_ecc;
  logic [5:0]  ecc_calc;
  logic        ecc_ok;

  assign hdr     = word_i[23:0];
  assign hdr_vc  = word_i[7:6];
  assign hdr_dt  = word_i[5:0];
  assign hdr_wc  = word_i[23:8];
  assign hdr_ecc = word_i[31:24];

  // CSI-2 6-bit Hamming parity over DI/WC, detection only
  assign ecc_calc[0] = hdr[0] ^ hdr[1] ^ hdr[2] ^ hdr[4] ^ hdr[5] ^ hdr[7] ^ hdr[10] ^
                       hdr[11] ^ hdr[13] ^ hdr[16] ^ hdr[20] ^ hdr[21] ^ hdr[22] ^ hdr[23];
  assign ecc_calc[1] = hdr[0] ^ hdr[1] ^ hdr[3] ^ hdr[4] ^ hdr[6] ^ hdr[8] ^ hdr[10] ^
                       hdr[12] ^ hdr[14] ^ hdr[17] ^ hdr[20] ^ hdr[21] ^ hdr[22] ^ hdr[23];
  assign ecc_calc[2] = hdr[0] ^ hdr[2] ^ hdr[3] ^ hdr[5] ^ hdr[6] ^ hdr[9] ^ hdr[11] ^
                       hdr[12] ^ hdr[15] ^ hdr[18] ^ hdr[20] ^ hdr[21] ^ hdr[22];
  assign ecc_calc[3] = hdr[1] ^ hdr[2] ^ hdr[3] ^ hdr[7] ^ hdr[8] ^ hdr[9] ^ hdr[13] ^
                       hdr[14] ^ hdr[15] ^ hdr[19] ^ hdr[20] ^ hdr[21] ^ hdr[23];
  assign ecc_calc[4] = hdr[4] ^ hdr[5] ^ hdr[6] ^ hdr[7] ^ hdr[8] ^ hdr[9] ^ hdr[16] ^
                       hdr[17] ^ hdr[18] ^ hdr[19] ^ hdr[20] ^ hdr[22] ^ hdr[23];
  assign ecc_calc[5] = hdr[10] ^ hdr[11] ^ hdr[12] ^ hdr[13] ^ hdr[14] ^ hdr[15] ^
                       hdr[16] ^ hdr[17] ^ hdr[18] ^ hdr[19] ^ hdr[21] ^ hdr[22] ^ hdr[23];

  assign ecc_ok = (hdr_ecc == {2'b00, ecc_calc});

  // Payload bookkeeping
  logic [2:0] consumed;
  logic       last_word;
  logic       take_hdr;
  logic       abort;
  logic       ecc_bad;
  logic [1:0] err_inc;
  logic [ERR_CNT_W:0] err_sum;

  assign consumed  = (remaining_q >= 16'd4) ? 3'd4 : remaining_q[2:0];
  assign last_word = (remaining_q <= 16'd4);
  assign take_hdr  = word_valid_i && sot_i;
  assign abort     = take_hdr && (state_q != StIdle);
  assign ecc_bad   = take_hdr && !ecc_ok;
  assign err_inc   = {1'b0, abort} + {1'b0, ecc_bad};
  assign err_sum   = {1'b0, err_count_q} + (ERR_CNT_W+1)'(err_inc);

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    wc_d         = wc_q;
    fwd_d        = fwd_q;
    data_d       = '0;
    data_valid_d = 1'b0;
    byte_en_d    = '0;
    fs_d         = 1'b0;
    fe_d         = 1'b0;
    ls_d         = 1'b0;
    le_d         = 1'b0;
    ecc_err_d    = 1'b0;
    frame_num_d  = frame_num_q;
    line_wc_d    = line_wc_q;
    err_count_d  = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];

    if (take_hdr) begin
      // sot always restarts header parsing, whatever state we were in
      state_d = StIdle;
      if (!ecc_ok) begin
        ecc_err_d = 1'b1;
      end else if (hdr_dt < 6'h10) begin
        if (hdr_vc == VC_FILTER) begin
          case (hdr_dt)
            6'h00: begin
              fs_d        = 1'b1;
              frame_num_d = hdr_wc;
            end
            6'h01:   fe_d = 1'b1;
            6'h02:   ls_d = 1'b1;
            6'h03:   le_d = 1'b1;
            default: ;
          endcase
        end
      end else begin
        remaining_d = hdr_wc;
        wc_d        = hdr_wc;
        fwd_d       = (hdr_vc == VC_FILTER) && (hdr_dt == DT_FILTER);
        state_d     = (hdr_wc == 16'd0) ? StFooter : StPayload;
      end
    end else if (word_valid_i) begin
      case (state_q)
        StPayload: begin
          if (fwd_q) begin
            data_valid_d = 1'b1;
            data_d       = word_i;
            case (consumed)
              3'd1:    byte_en_d = 4'h1;
              3'd2:    byte_en_d = 4'h3;
              3'd3:    byte_en_d = 4'h7;
              default: byte_en_d = 4'hF;
            endcase
          end
          remaining_d = remaining_q - 16'(consumed);
          if (last_word) begin
            // One or two tail bytes leave room for the whole CRC in this word
            state_d = (wc_q[1:0] == 2'd1 || wc_q[1:0] == 2'd2) ? StIdle : StFooter;
            if (fwd_q) line_wc_d = wc_q;
          end
        end
        StFooter: state_d = StIdle;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      wc_q         <= '0;
      fwd_q        <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      byte_en_q    <= '0;
      fs_q         <= 1'b0;
      fe_q         <= 1'b0;
      ls_q         <= 1'b0;
      le_q         <= 1'b0;
      frame_num_q  <= '0;
      line_wc_q    <= '0;
      ecc_err_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      wc_q         <= wc_d;
      fwd_q        <= fwd_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      byte_en_q    <= byte_en_d;
      fs_q         <= fs_d;
      fe_q         <= fe_d;
      ls_q         <= ls_d;
      le_q         <= le_d;
      frame_num_q  <= frame_num_d;
      line_wc_q    <= line_wc_d;
      ecc_err_q    <= ecc_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign byte_en_o    = byte_en_q;
  assign fs_o         = fs_q;
  assign fe_o         = fe_q;
  assign ls_o         = ls_q;
  assign le_o         = le_q;
  assign frame_num_o  = frame_num_q;
  assign line_wc_o    = line_wc_q;
  assign ecc_err_o    = ecc_err_q;
  assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_mipi_csi_pkt_parser.sv
// Scoreboard bench for mipi_csi_pkt_parser: stimulus queues cycle-stamped expected
// output events, an independent monitor compares them against the DUT every cycle.
module tb_mipi_csi_pkt_parser;

  logic        clk_i;
  logic        reset_n;
  logic [31:0] word_i;
  logic        word_valid_i;
  logic        sot_i;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic [3:0]  byte_en_o;
  logic        fs_o, fe_o, ls_o, le_o;
  logic [15:0] frame_num_o;
  logic [15:0] line_wc_o;
  logic        ecc_err_o;
  logic [15:0] err_count_o;

  mipi_csi_pkt_parser #(
    .DT_FILTER(6'h2B),
    .VC_FILTER(2'd0),
    .ERR_CNT_W(16)
  ) dut (
    .clk_i       (clk_i),
    .reset_n     (reset_n),
    .word_i      (word_i),
    .word_valid_i(word_valid_i),
    .sot_i       (sot_i),
    .data_o      (data_o),
    .data_valid_o(data_valid_o),
    .byte_en_o   (byte_en_o),
    .fs_o        (fs_o),
    .fe_o        (fe_o),
    .ls_o        (ls_o),
    .le_o        (le_o),
    .frame_num_o (frame_num_o),
    .line_wc_o   (line_wc_o),
    .ecc_err_o   (ecc_err_o),
    .err_count_o (err_count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  // Event vector: {dv, be[3:0], data[31:0], fs, fe, ls, le, ecc_err}
  typedef struct packed {
    int unsigned cyc;
    logic [41:0] ev;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, req);
  endtask

  function automatic logic [41:0] mk_ev(logic dv, logic [3:0] be, logic [31:0] d, logic fs,
                                         logic fe, logic ls, logic le, logic ee);
    return {dv, be, d, fs, fe, ls, le, ee};
  endfunction

  // Parity masks of the CSI-2 header ECC, one 24-bit mask per ECC bit
  function automatic logic [7:0] ecc_of(logic [23:0] h);
    logic [7:0] e;
    e    = '0;
    e[0] = ^(h & 24'hF12CB7);
    e[1] = ^(h & 24'hF2555B);
    e[2] = ^(h & 24'h749A6D);
    e[3] = ^(h & 24'hB8E38E);
    e[4] = ^(h & 24'hDF03F0);
    e[5] = ^(h & 24'hEFFC00);
    return e;
  endfunction

  function automatic logic [31:0] hdr(logic [7:0] di, logic [15:0] wc);
    return {ecc_of({wc, di}), wc, di};
  endfunction

  task automatic drive(input logic [31:0] w, input logic v, input logic s);
    @(posedge clk_i);
    #1;
    word_i       = w;
    word_valid_i = v;
    sot_i        = s;
  endtask

  task automatic expect_ev(input logic [41:0] ev);
    exp_t e;
    e.cyc = cyc + 1;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  task automatic pay(input logic [31:0] w, input logic [3:0] be);
    drive(w, 1'b1, 1'b0);
    expect_ev(mk_ev(1'b1, be, w, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 1'b0);
  endtask

  always @(negedge clk_i) begin
    logic [41:0] obs;
    exp_t        e;
    obs = {data_valid_o, byte_en_o, data_o, fs_o, fe_o, ls_o, le_o, ecc_err_o};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_total++;
      $display("FAIL missing_event cyc=%0d: got nothing required %0h", e.cyc, e.ev);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("event", {22'd0, obs}, {22'd0, e.ev});
    end else if (obs != '0) begin
      check("unexpected_event", {22'd0, obs}, 64'd0);
    end
  end

  initial begin
    reset_n      = 1'b0;
    word_i       = '0;
    word_valid_i = 1'b0;
    sot_i        = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs", {data_valid_o, byte_en_o, data_o, fs_o, fe_o, ls_o, le_o, ecc_err_o},
          64'd0);
    check("reset_status", {frame_num_o, line_wc_o, err_count_o}, 64'd0);
    @(negedge clk_i);
    reset_n = 1'b1;

    // Frame Start, frame number 1
    drive(hdr(8'h00, 16'h0001), 1'b1, 1'b1);
    expect_ev(mk_ev(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    idle();
    check("fs_frame_num", frame_num_o, 64'h1);

    // RAW10 WC=10: F,F,3 then straight back to header parsing
    drive(hdr(8'h2B, 16'd10), 1'b1, 1'b1);
    pay(32'h11223344, 4'hF);
    pay(32'h55667788, 4'hF);
    pay(32'hC0DE99AA, 4'h3);
    drive(hdr(8'h03, 16'h0000), 1'b1, 1'b1);
    expect_ev(mk_ev(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    idle();
    check("wc10_line_wc", line_wc_o, 64'd10);
    check("wc10_no_abort", err_count_o, 64'd0);

    // WC=8: two full words, footer word swallowed
    drive(hdr(8'h2B, 16'd8), 1'b1, 1'b1);
    pay(32'hA0A1A2A3, 4'hF);
    pay(32'hB0B1B2B3, 4'hF);
    drive(32'hCCCC1234, 1'b1, 1'b0);
    drive(hdr(8'h01, 16'h0001), 1'b1, 1'b1);
    expect_ev(mk_ev(1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    idle();
    check("wc8_line_wc", line_wc_o, 64'd8);
    check("wc8_no_abort", err_count_o, 64'd0);

    // ECC corruption: flipped parity bit, then reserved bit 6 set
    drive(hdr(8'h02, 16'h0005) ^ 32'h0100_0000, 1'b1, 1'b1);
    expect_ev(mk_ev(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    idle();
    check("ecc_err_count1", err_count_o, 64'd1);
    drive(hdr(8'h02, 16'h0005) | 32'h4000_0000, 1'b1, 1'b1);
    expect_ev(mk_ev(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    idle();
    check("ecc_err_count2", err_count_o, 64'd2);

    // Filtered long packets (VC1 RAW10, VC0 RAW8), WC=16 each
    drive(hdr(8'h6B, 16'd16), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(32'h6B000000 + 32'(i), 1'b1, 1'b0);
    drive(hdr(8'h2A, 16'd16), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(32'h2A000000 + 32'(i), 1'b1, 1'b0);
    drive(hdr(8'h02, 16'h0000), 1'b1, 1'b1);
    expect_ev(mk_ev(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    idle();
    check("filter_no_abort", err_count_o, 64'd2);
    check("filter_line_wc", line_wc_o, 64'd8);

    // WC=7: tail of three bytes, one CRC byte in a footer word
    drive(hdr(8'h2B, 16'd7), 1'b1, 1'b1);
    pay(32'h01020304, 4'hF);
    pay(32'hEE050607, 4'h7);
    drive(32'h000000EE, 1'b1, 1'b0);
    drive(hdr(8'h00, 16'h0002), 1'b1, 1'b1);
    expect_ev(mk_ev(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    idle();
    check("wc7_frame_num", frame_num_o, 64'h2);
    check("wc7_line_wc", line_wc_o, 64'd7);
    check("wc7_no_abort", err_count_o, 64'd2);

    // WC=5: single tail byte, CRC finishes in the same word
    drive(hdr(8'h2B, 16'd5), 1'b1, 1'b1);
    pay(32'h0A0B0C0D, 4'hF);
    pay(32'hDDCCBB0E, 4'h1);
    drive(hdr(8'h01, 16'h0002), 1'b1, 1'b1);
    expect_ev(mk_ev(1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    idle();
    check("wc5_line_wc", line_wc_o, 64'd5);
    check("wc5_no_abort", err_count_o, 64'd2);

    // Abort after 2 of 5 payload words; the sot word is honoured as LS
    drive(hdr(8'h2B, 16'd20), 1'b1, 1'b1);
    pay(32'h12345678, 4'hF);
    pay(32'h9ABCDEF0, 4'hF);
    drive(hdr(8'h02, 16'h0000), 1'b1, 1'b1);
    expect_ev(mk_ev(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    drive(32'h77777777, 1'b1, 1'b0);
    idle();
    check("abort_err_count", err_count_o, 64'd3);
    check("abort_line_wc", line_wc_o, 64'd5);

    // Async reset mid-payload
    drive(hdr(8'h2B, 16'd20), 1'b1, 1'b1);
    pay(32'hFACEB00C, 4'hF);
    pay(32'hDEADBEEF, 4'hF);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    reset_n      = 1'b0;
    word_valid_i = 1'b0;
    #1;
    check("areset_outputs",
          {data_valid_o, byte_en_o, data_o, fs_o, fe_o, ls_o, le_o, ecc_err_o}, 64'd0);
    check("areset_status", {frame_num_o, line_wc_o, err_count_o}, 64'd0);
    @(negedge clk_i);
    reset_n = 1'b1;
    drive(32'h5A5A5A5A, 1'b1, 1'b0);
    drive(hdr(8'h00, 16'h0003), 1'b1, 1'b1);
    expect_ev(mk_ev(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    idle();
    check("post_reset_frame_num", frame_num_o, 64'h3);
    check("post_reset_err_count", err_count_o, 64'd0);

    repeat (4) @(posedge clk_i);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
